adder_ds_ctrl: RTL

//  Request-side sequencer for the adder_ds datapath register (sum/pass register with SEL_0/SEL_1).
//  - Accepts one operation per transaction over a valid/ready request port.
//  - Drives the datapath's DATA_1/DATA_2/SEL_0/SEL_1 inputs and waits out its 1-cycle register latency.
//  - Captures the datapath's reg_0 output and returns it over a valid/ready response port, with a carry flag.

---
 rtl/adder_ds_ctrl_if.sv | 34 +++
 rtl/adder_ds_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/adder_ds_ctrl_if.sv
// Request/response/datapath bundle for the adder_ds request-side sequencer.
// The slave side is the sequencer; the master side is the requester plus the datapath model.
interface adder_ds_ctrl_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [N-1:0]     req_a;
    logic [N-1:0]     req_b;
    logic [N-1:0]     dp_data_1;
    logic [N-1:0]     dp_data_2;
    logic             dp_sel_0;
    logic             dp_sel_1;
    logic [N-1:0]     dp_reg_0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_data;
    logic             rsp_carry;
    logic [CNT_W-1:0] txn_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b, dp_reg_0, rsp_ready,
        output req_ready, dp_data_1, dp_data_2, dp_sel_0, dp_sel_1,
               rsp_valid, rsp_data, rsp_carry, txn_count
    );

    modport master (
        output req_valid, req_op, req_a, req_b, dp_reg_0, rsp_ready,
        input  req_ready, dp_data_1, dp_data_2, dp_sel_0, dp_sel_1,
               rsp_valid, rsp_data, rsp_carry, txn_count
    );
endinterface

// File: rtl/adder_ds_ctrl.sv
// Sequencer driving the adder_ds sum/pass register: accept, issue, capture, respond.
// Define ADDER_DS_ISOLATE_EN to hold datapath inputs at 0 outside the issue cycle.
module adder_ds_ctrl #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_ds_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_rsp_data;
    logic             r_rsp_carry;
    logic [CNT_W-1:0] r_txn_count;

    logic             w_req_ready;
    logic             w_rsp_valid;
    logic             w_accept;
    logic             w_rsp_hs;
    logic             w_dp_en;

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_accept     = 1'b0;
        w_rsp_hs     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_CAPT;
            S_CAPT:  w_state_next = S_RESP;
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_rsp_hs     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op <= bus.req_op;
                r_a  <= bus.req_a;
                r_b  <= bus.req_b;
            end
            // Datapath has wrapped the sum mod 2^N; a wrap shows up as result < A.
            if (r_state == S_CAPT) begin
                r_rsp_data  <= bus.dp_reg_0;
                r_rsp_carry <= (r_op == 2'b01) && (bus.dp_reg_0 < r_a);
            end
            if (w_rsp_hs) begin
                r_txn_count <= r_txn_count + 1'b1;
            end
        end
    end

`ifdef ADDER_DS_ISOLATE_EN
    assign w_dp_en = (r_state == S_ISSUE);
`else
    assign w_dp_en = 1'b1;
`endif

    assign bus.dp_data_1 = w_dp_en ? r_a : '0;
    assign bus.dp_data_2 = w_dp_en ? r_b : '0;
    assign bus.dp_sel_1  = w_dp_en & r_op[1];
    assign bus.dp_sel_0  = w_dp_en & ~r_op[1] & r_op[0];

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.txn_count = r_txn_count;
endmodule
